dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU memory stage and the 128-bit block data memory.
- Acts as the initiator of the block-memory read/write/busywait protocol. The data memory is the responder.
- Serves 32-bit word loads and byte-masked stores from the CPU, and stalls the pipeline with cpu_busywait on a miss.

---
 rtl/dcache_controller_pkg.sv | 24 ++
 rtl/dcache_line_array.sv | 86 ++++++++
 rtl/dcache_controller.sv | 159 +++++++++++++++
 tb/tb_dcache_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Holds the address field layout, the array geometry and the controller
// state encoding, so that the top and the line array agree on them.
package dcache_controller_pkg;

  localparam int NUM_SETS   = 8;
  localparam int TAG_WIDTH  = 25;
  localparam int INDEX_W    = 3;
  localparam int BLOCK_W    = 128;
  localparam int BLK_ADDR_W = 28;

  // Byte address layout: [31:7] tag, [6:4] index, [3:2] word, [1:0] ignored.
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = 4;
  localparam int TAG_LSB    = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } cache_state_e;

endpackage

// File: rtl/dcache_line_array.sv
// Line storage for the data cache: per-line valid, dirty, tag and 128-bit data.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-low reset
//                         (clears valid and dirty only)
//   rd_index            : combinational read port select
//   rd_valid/rd_dirty/rd_tag/rd_data : contents of line rd_index
//   wr_en, wr_fill      : single write port; wr_fill=1 loads a whole line
//                         (valid=1, dirty=0), wr_fill=0 merges a word (dirty=1)
//   wr_index            : line written
//   fill_tag, fill_data : new tag and block for a fill
//   word_sel, word_data, word_byteen : word lane and byte-masked data for a merge
module dcache_line_array
  import dcache_controller_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INDEX_W-1:0]   rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic [BLOCK_W-1:0]   rd_data,
  input  logic                 wr_en,
  input  logic                 wr_fill,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic [BLOCK_W-1:0]   fill_data,
  input  logic [1:0]           word_sel,
  input  logic [31:0]          word_data,
  input  logic [3:0]           word_byteen
);

  logic [NUM_SETS-1:0]  valid_q, valid_d;
  logic [NUM_SETS-1:0]  dirty_q, dirty_d;
  logic [TAG_WIDTH-1:0] tag_q  [NUM_SETS];
  logic [TAG_WIDTH-1:0] tag_d  [NUM_SETS];
  logic [BLOCK_W-1:0]   data_q [NUM_SETS];
  logic [BLOCK_W-1:0]   data_d [NUM_SETS];
  logic [6:0]           byte_lsb;

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_comb begin
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    tag_d    = tag_q;
    data_d   = data_q;
    byte_lsb = '0;
    if (wr_en) begin
      if (wr_fill) begin
        valid_d[wr_index] = 1'b1;
        dirty_d[wr_index] = 1'b0;
        tag_d[wr_index]   = fill_tag;
        data_d[wr_index]  = fill_data;
      end else begin
        dirty_d[wr_index] = 1'b1;
        for (int i = 0; i < 4; i++) begin
          // Bit position of byte i inside the selected word of the block.
          byte_lsb = {word_sel, i[1:0], 3'b000};
          if (word_byteen[i]) begin
            data_d[wr_index][byte_lsb +: 8] = word_data[i*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data need no reset: they are meaningless while valid is clear.
  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-low reset
//   cpu_read/cpu_write/cpu_address/cpu_writedata/cpu_byteen : CPU request,
//                    held until cpu_busywait==0 (write wins if both set)
//   cpu_readdata   : addressed word of the line (zero when not hitting)
//   cpu_busywait   : combinational stall, high for any request not hitting in IDLE
//   mem_read/mem_write/mem_address/mem_writedata/mem_readdata/mem_busywait :
//                    block memory initiator side
//   dbg_state      : current controller state
//
// Memory handshake: the cache raises mem_read or mem_write (never both) and
// holds it, with a stable address and write data, for the whole state. The
// responder raises mem_busywait after seeing the request and drops it when the
// access completes. The first cycle of a state only marks the request as issued,
// so a responder that has not yet raised busywait is not taken as finished; the
// access completes on the first edge with issued set and mem_busywait low.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_address,
  input  logic [31:0]           cpu_writedata,
  input  logic [3:0]            cpu_byteen,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [BLK_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait,
  output logic [1:0]            dbg_state
);

  cache_state_e          state_q, state_d;
  logic                  issued_q, issued_d;
  logic [BLK_ADDR_W-1:0] miss_blk_q, miss_blk_d;

  logic                  req;
  logic                  hit;
  logic [INDEX_W-1:0]    rd_index;
  logic                  rd_valid, rd_dirty;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic [BLOCK_W-1:0]    rd_data;
  logic [3:0][31:0]      rd_words;
  logic                  wr_en, wr_fill;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^cpu_address[OFFSET_LSB-1:0];
  assign req = cpu_read | cpu_write;

  // One read port: the CPU index while idle, the latched miss line otherwise,
  // so victim tag/data stay stable even if the CPU drops its request.
  assign rd_index = (state_q == IDLE) ? cpu_address[INDEX_LSB +: INDEX_W]
                                      : miss_blk_q[INDEX_W-1:0];
  assign hit      = rd_valid && (rd_tag == cpu_address[TAG_LSB +: TAG_WIDTH]);
  assign rd_words = rd_data;
  assign dbg_state = state_q;

  dcache_line_array u_lines (
    .clock       (clock),
    .reset       (reset),
    .rd_index    (rd_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .wr_en       (wr_en),
    .wr_fill     (wr_fill),
    .wr_index    (rd_index),
    .fill_tag    (miss_blk_q[BLK_ADDR_W-1:INDEX_W]),
    .fill_data   (mem_readdata),
    .word_sel    (cpu_address[OFFSET_LSB +: 2]),
    .word_data   (cpu_writedata),
    .word_byteen (cpu_byteen)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      issued_q   <= 1'b0;
      miss_blk_q <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      miss_blk_q <= miss_blk_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    miss_blk_d = miss_blk_q;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          miss_blk_d = cpu_address[31:INDEX_LSB];
          issued_d   = 1'b0;
          state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (!mem_busywait) begin
          issued_d = 1'b0;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (!mem_busywait) begin
          issued_d = 1'b0;
          state_d  = UPDATE;
        end
      end
      UPDATE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    wr_en         = 1'b0;
    wr_fill       = 1'b0;
    cpu_busywait  = req && !((state_q == IDLE) && hit);
    cpu_readdata  = hit ? rd_words[cpu_address[OFFSET_LSB +: 2]] : 32'h0;
    unique case (state_q)
      IDLE: begin
        // Store hit (including read+write together) merges at this edge.
        wr_en = hit && cpu_write;
      end
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {rd_tag, miss_blk_q[INDEX_W-1:0]};
        mem_writedata = rd_data;
      end
      ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = miss_blk_q;
        wr_fill     = 1'b1;
        wr_en       = issued_q && !mem_busywait;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller with a block-memory responder,
// a flat reference memory for expected load data, and a read scoreboard.
module tb_dcache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_address, cpu_writedata;
  logic [3:0]   cpu_byteen;
  logic [31:0]  cpu_readdata;
  logic         cpu_busywait;
  logic         mem_read, mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [1:0]   dbg_state;

  dcache_controller dut (
    .clock         (clock),
    .reset         (reset),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_writedata (cpu_writedata),
    .cpu_byteen    (cpu_byteen),
    .cpu_readdata  (cpu_readdata),
    .cpu_busywait  (cpu_busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .dbg_state     (dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  // Counters and scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  ref_w [256];
  logic [127:0] mem_blk [64];

  // Responder observations
  int           n_rd_req = 0;
  int           n_wr_req = 0;
  logic [27:0]  last_rd_addr = '0;
  logic [27:0]  last_wr_addr = '0;
  logic [127:0] last_wr_data = '0;
  logic         both_seen = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int blk, input int w);
    if (blk == 0) return (w == 0) ? 32'h00FF0000 : 32'h0;
    return {8'hA5, 8'(blk), 8'(w), 8'h3C};
  endfunction

  // Block memory responder: busy for 1..4 cycles after accepting a request,
  // then ignores the still-held request for one cycle while the cache moves on.
  logic       pend_rd;
  logic [5:0] pend_addr;
  logic [127:0] pend_data;
  logic [1:0] cnt;
  logic       hold;

  always @(posedge clock) begin
    if (!reset) begin
      mem_busywait <= 1'b0;
      hold         <= 1'b0;
      cnt          <= '0;
    end else if (hold) begin
      hold <= 1'b0;
    end else if (mem_busywait) begin
      if (cnt == 2'd0) begin
        mem_busywait <= 1'b0;
        hold         <= 1'b1;
        if (pend_rd) mem_readdata <= mem_blk[pend_addr];
        else         mem_blk[pend_addr] <= pend_data;
      end else begin
        cnt <= cnt - 2'd1;
      end
    end else if (mem_read || mem_write) begin
      mem_busywait <= 1'b1;
      cnt          <= 2'($urandom_range(0, 3));
      pend_rd      <= mem_read;
      pend_addr    <= mem_address[5:0];
      pend_data    <= mem_writedata;
      if (mem_read) begin
        n_rd_req     <= n_rd_req + 1;
        last_rd_addr <= mem_address;
      end else begin
        n_wr_req     <= n_wr_req + 1;
        last_wr_addr <= mem_address;
        last_wr_data <= mem_writedata;
      end
    end
  end

  always @(negedge clock) begin
    if (mem_read && mem_write) both_seen <= 1'b1;
  end

  // Driver: one CPU access held until the stall clears. Load data is checked
  // against the scoreboard; stores update the reference memory.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be,
                           output int stalls, output logic [31:0] rdata);
    logic [31:0] e;
    logic [31:0] w;
    @(negedge clock);
    cpu_read      = rd;
    cpu_write     = wr;
    cpu_address   = addr;
    cpu_writedata = wd;
    cpu_byteen    = be;
    if (rd && !wr) exp_q.push_back(ref_w[addr[9:2]]);
    #1;
    stalls = 0;
    while (cpu_busywait && stalls < 200) begin
      @(negedge clock);
      #1;
      stalls++;
    end
    check("busywait_release", cpu_busywait, 0);
    rdata = cpu_readdata;
    if (rd && !wr) begin
      e = exp_q.pop_front();
      check("load_data", cpu_readdata, e);
    end
    if (wr) begin
      w = ref_w[addr[9:2]];
      for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
      ref_w[addr[9:2]] = w;
    end
    @(posedge clock);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int waited;
    logic [31:0] rd;
    int nrd0, nwr0;

    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        mem_blk[b][w*32 +: 32] = init_word(b, w);
        ref_w[b*4 + w]         = init_word(b, w);
      end
    end
    mem_readdata  = '0;
    reset         = 1'b0;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_address   = '0;
    cpu_writedata = '0;
    cpu_byteen    = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busywait", cpu_busywait, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_readdata", cpu_readdata, 0);
    check("rst_state", dbg_state, 2'd0);
    @(negedge clock);
    reset = 1'b1;

    // Cold miss on block 0
    nrd0 = n_rd_req; nwr0 = n_wr_req;
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, st, rd);
    check("t1_stalled", st > 0, 1);
    check("t1_data", rd, 32'h00FF0000);
    check("t1_rd_reqs", n_rd_req - nrd0, 1);
    check("t1_rd_addr", last_rd_addr, 28'h0);
    check("t1_no_wr", n_wr_req - nwr0, 0);

    // Hit on the same line
    nrd0 = n_rd_req;
    do_access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, st, rd);
    check("t2_stall", st, 0);
    check("t2_data", rd, 32'h0);
    check("t2_no_req", n_rd_req - nrd0, 0);

    // Byte-masked store hit, then read it back
    do_access(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 4'b0011, st, rd);
    check("t3_wr_stall", st, 0);
    do_access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, st, rd);
    check("t3_rd_stall", st, 0);
    check("t3_data", rd, 32'h0000BEEF);

    // Conflict miss on a dirty line: writeback then allocate
    nrd0 = n_rd_req; nwr0 = n_wr_req;
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, st, rd);
    check("t4_wr_reqs", n_wr_req - nwr0, 1);
    check("t4_wb_addr", last_wr_addr, 28'h0);
    check("t4_wb_word2", last_wr_data[95:64], 32'h0000BEEF);
    check("t4_rd_reqs", n_rd_req - nrd0, 1);
    check("t4_alloc_addr", last_rd_addr, 28'h8);
    check("t4_data", rd, 32'hA5_08_00_3C);

    // Fill line 1 so the reset below must invalidate more than one line
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, st, rd);

    // Reset in the middle of an allocate
    @(negedge clock);
    cpu_read    = 1'b1;
    cpu_address = 32'h100;
    waited = 0;
    while (!mem_read && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("t5_in_alloc", mem_read, 1);
    reset    = 1'b0;
    cpu_read = 1'b0;
    @(posedge clock);
    #1;
    check("t5_mem_read", mem_read, 0);
    check("t5_mem_write", mem_write, 0);
    check("t5_state", dbg_state, 2'd0);
    check("t5_busywait", cpu_busywait, 0);
    @(negedge clock);
    reset = 1'b1;
    nrd0 = n_rd_req;
    do_access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, st, rd);
    check("t5_line0_miss", st > 0, 1);
    check("t5_refetch", n_rd_req - nrd0, 1);
    check("t5_data", rd, 32'h00FF0000);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, st, rd);
    check("t5_line1_miss", st > 0, 1);

    // Read and write together on a hit behave as a store
    do_access(1'b1, 1'b1, 32'h4, 32'h12345678, 4'b1111, st, rd);
    check("t6_stall", st, 0);
    do_access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, st, rd);
    check("t6_data", rd, 32'h12345678);
    nwr0 = n_wr_req;
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, st, rd);
    check("t6_dirty_wb", n_wr_req - nwr0, 1);
    check("t6_wb_word1", last_wr_data[63:32], 32'h12345678);

    // Random mixed traffic over 64 blocks against the reference memory
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      int op;
      a  = {22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), 2'b00};
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), st, rd);
    end

    check("never_both_req", both_seen, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
